// File: rtl/nrisc_pkg.sv
// Shared constants, state encoding and helpers for the nRisc boot sequencer.
// Address/data widths are fixed at one byte to match the nRisc memories.
package nrisc_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned CYCLE_W = 16;

    localparam logic [DATA_W-1:0] HALT_OPCODE_DEFAULT = 8'h00;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ICNT = 3'd1,
        LOAD_I   = 3'd2,
        GET_DCNT = 3'd3,
        LOAD_D   = 3'd4,
        RUN      = 3'd5,
        HALTED   = 3'd6
    } boot_state_e;

    // Saturating increment for the run-cycle counter.
    function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v);
        return (v == {CYCLE_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/boot_load_counter.sv
// One byte-load channel: latches the byte count, then writes each loaded byte
// to consecutive addresses as a one-cycle strobe the cycle after it transfers.
module boot_load_counter
    import nrisc_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic              clear_i,
    input  logic              count_sel_i,
    input  logic              load_sel_i,
    input  logic              xfer_i,
    input  logic [DATA_W-1:0] byte_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              count_zero_o,
    output logic              done_o
);

    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] idx_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge Clock) begin
        if (Reset || clear_i) begin
            count_q <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            we_q <= 1'b0;
            if (count_sel_i && xfer_i) begin
                count_q <= byte_i;
            end
            if (load_sel_i && xfer_i) begin
                we_q   <= 1'b1;
                addr_q <= idx_q;
                data_q <= byte_i;
                idx_q  <= idx_q + 1'b1;
            end
        end
    end

    // Count is at most 255, so idx_q never passes count_q and never wraps.
    assign count_zero_o = (byte_i == '0);
    assign done_o       = load_sel_i && xfer_i && (idx_q == count_q - ADDR_W'(1));

    assign we_o   = we_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/boot_sequencer.sv
// Boot sequencer: streams an instruction image and a data image into the nRisc
// memories, releases the core from reset, then watches for halt or watchdog.
module boot_sequencer
    import nrisc_pkg::*;
#(
    parameter logic [DATA_W-1:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT,
    parameter logic [CYCLE_W-1:0] MAX_CYCLES  = 16'd1000
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [DATA_W-1:0]  InByte,
    input  logic               InValid,
    output logic               InReady,
    output logic               ImemWe,
    output logic [ADDR_W-1:0]  ImemAddr,
    output logic [DATA_W-1:0]  ImemData,
    output logic               DmemWe,
    output logic [ADDR_W-1:0]  DmemAddr,
    output logic [DATA_W-1:0]  DmemData,
    output logic               CpuReset,
    input  logic [DATA_W-1:0]  CpuInstr,
    output logic               Busy,
    output logic               Halted,
    output logic               TimedOut,
    output logic [CYCLE_W-1:0] CycleCount
);

    boot_state_e        state_q, state_d;
    logic               in_ready_q;
    logic               cpu_reset_q;
    logic               busy_q;
    logic               halted_q;
    logic               timed_out_q;
    logic [CYCLE_W-1:0] cycle_q;

    logic               xfer;
    logic               start_go;
    logic [CYCLE_W-1:0] cycle_inc;
    logic               opcode_halt;
    logic               watchdog;
    logic               i_zero, i_done, d_zero, d_done;

    // A byte moves only when the registered InReady and InValid coincide.
    assign xfer      = InValid && in_ready_q;
    assign start_go  = Start && (state_q == IDLE || state_q == HALTED);
    assign cycle_inc = sat_inc(cycle_q);
    // cycle_q is 0 only on the first RUN cycle, while the fetch settles.
    assign opcode_halt = (state_q == RUN) && (cycle_q != '0) && (CpuInstr == HALT_OPCODE);
    assign watchdog    = (state_q == RUN) && (cycle_inc == MAX_CYCLES);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start_go) state_d = GET_ICNT;
            GET_ICNT: if (xfer)     state_d = i_zero ? GET_DCNT : LOAD_I;
            LOAD_I:   if (i_done)   state_d = GET_DCNT;
            GET_DCNT: if (xfer)     state_d = d_zero ? RUN : LOAD_D;
            LOAD_D:   if (d_done)   state_d = RUN;
            RUN:      if (opcode_halt || watchdog) state_d = HALTED;
            HALTED:   if (start_go) state_d = GET_ICNT;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            timed_out_q <= 1'b0;
            cycle_q     <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= state_d inside {GET_ICNT, LOAD_I, GET_DCNT, LOAD_D};
            cpu_reset_q <= (state_d != RUN);
            busy_q      <= !(state_d inside {IDLE, HALTED});
            if (start_go) begin
                halted_q    <= 1'b0;
                timed_out_q <= 1'b0;
                cycle_q     <= '0;
            end else if (state_q == RUN) begin
                cycle_q <= cycle_inc;
                // Opcode halt has priority; TimedOut only when the watchdog alone fires.
                if (opcode_halt) begin
                    halted_q <= 1'b1;
                end else if (watchdog) begin
                    halted_q    <= 1'b1;
                    timed_out_q <= 1'b1;
                end
            end else if (state_d == RUN) begin
                cycle_q <= '0;
            end
        end
    end

    boot_load_counter u_imem_ch (
        .Clock        (Clock),
        .Reset        (Reset),
        .clear_i      (start_go),
        .count_sel_i  (state_q == GET_ICNT),
        .load_sel_i   (state_q == LOAD_I),
        .xfer_i       (xfer),
        .byte_i       (InByte),
        .we_o         (ImemWe),
        .addr_o       (ImemAddr),
        .data_o       (ImemData),
        .count_zero_o (i_zero),
        .done_o       (i_done)
    );

    boot_load_counter u_dmem_ch (
        .Clock        (Clock),
        .Reset        (Reset),
        .clear_i      (start_go),
        .count_sel_i  (state_q == GET_DCNT),
        .load_sel_i   (state_q == LOAD_D),
        .xfer_i       (xfer),
        .byte_i       (InByte),
        .we_o         (DmemWe),
        .addr_o       (DmemAddr),
        .data_o       (DmemData),
        .count_zero_o (d_zero),
        .done_o       (d_done)
    );

    assign InReady    = in_ready_q;
    assign CpuReset   = cpu_reset_q;
    assign Busy       = busy_q;
    assign Halted     = halted_q;
    assign TimedOut   = timed_out_q;
    assign CycleCount = cycle_q;

endmodule
